// File: rtl/arb4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb4_pkg
// Purpose  : Shared types and sizes for the 4-way round-robin arbiter
// Revision : 1.0
// ============================================================================
package arb4_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arb4_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : arb4_rr_if
// Purpose  : Request/grant bundle between requesters and the arbiter
// Revision : 1.0
// ============================================================================
interface arb4_rr_if;
  import arb4_pkg::*;

  logic [N_REQ-1:0] req;
  logic             mode;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output mode,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  mode,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/prio_enc4.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc4
// Purpose  : Combinational 4-to-2 priority encoder, bit 3 highest
// Revision : 1.0
// ============================================================================
module prio_enc4
  import arb4_pkg::*;
(
  input  wire logic [N_REQ-1:0] vec,
  output logic      [ID_W-1:0]  idx,
  output logic                  any
);

  always_comb begin
    any = |vec;
    idx = '0;
    if (vec[3]) begin
      idx = 2'd3;
    end else if (vec[2]) begin
      idx = 2'd2;
    end else if (vec[1]) begin
      idx = 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb4_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb4_rr
// Purpose  : 4-way arbiter, fixed or round-robin order, bounded hold time
// Revision : 1.0
// ============================================================================
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input wire logic  clk,
  input wire logic  rst_n,
  arb4_rr_if.slave  bus
);

  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_hold_cnt;
  logic [7:0]       w_hold_nxt;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  w_last_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  w_gnt_id_nxt;
  logic             r_gnt_valid;
  logic             w_gnt_valid_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic [ID_W-1:0]    w_shift;
  logic [2*N_REQ-1:0] w_req_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_enc_idx;
  logic               w_any;
  logic [ID_W-1:0]    w_win;
  logic               w_owner_req;
  logic               w_expire;

  // Rotating by last puts req[last-1] on bit 3, so the encoder's fixed
  // 3..0 order becomes the round-robin order; un-rotate by adding back.
  always_comb begin
    w_shift   = bus.mode ? r_last : '0;
    w_req_dbl = {bus.req, bus.req};
    w_rot     = w_req_dbl[w_shift +: N_REQ];
    w_win     = w_enc_idx + w_shift;
  end

  prio_enc4 u_enc (
    .vec (w_rot),
    .idx (w_enc_idx),
    .any (w_any)
  );

  assign w_owner_req = bus.req[r_gnt_id];
  assign w_expire    = (r_hold_cnt == c_hold_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = BUSY;
      BUSY:    if (!w_owner_req || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_hold_nxt      = r_hold_cnt;
    w_last_nxt      = r_last;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_nxt      = '0;
        w_gnt_nxt       = '0;
        w_gnt_id_nxt    = '0;
        w_gnt_valid_nxt = 1'b0;
        if (w_any) begin
          w_gnt_nxt[w_win] = 1'b1;
          w_gnt_id_nxt     = w_win;
          w_gnt_valid_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (!w_owner_req || w_expire) begin
          w_gnt_nxt       = '0;
          w_gnt_id_nxt    = '0;
          w_gnt_valid_nxt = 1'b0;
          w_last_nxt      = r_gnt_id;
          // Only a still-requesting owner is being forced off.
          w_timeout_nxt   = w_owner_req;
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_gnt_id_nxt    = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
      r_last      <= '0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb4_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb4_rr
// Purpose  : Directed and random checks of arb4_rr against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_arb4_rr;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  arb4_rr_if bus();

  arb4_rr #(.MAX_HOLD(MAX_HOLD)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: who owns the resource, for how many cycles so far.
  bit       m_busy  = 1'b0;
  int       m_owner = 0;
  int       m_held  = 0;
  int       m_last  = 0;
  bit [3:0] m_gnt   = '0;
  int       m_id    = 0;
  bit       m_valid = 1'b0;
  bit       m_tmo   = 1'b0;

  int  starve [4];
  bit  prev_valid;
  bit  chk_starve;

  function automatic int pick(input logic [3:0] r, input logic md, input int lst);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = md ? (lst + 8 - k) % 4 : 4 - k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic md, input logic rn);
    int w;
    m_tmo = 1'b0;
    if (!rn) begin
      m_busy = 1'b0; m_held = 0; m_last = 0;
      m_gnt = '0; m_id = 0; m_valid = 1'b0;
    end else if (!m_busy) begin
      w = pick(r, md, m_last);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_held = 1;
        m_gnt = 4'(1 << w); m_id = w; m_valid = 1'b1;
      end else begin
        m_gnt = '0; m_id = 0; m_valid = 1'b0;
      end
    end else if (!r[m_owner] || m_held == MAX_HOLD) begin
      m_tmo  = r[m_owner];
      m_busy = 1'b0; m_last = m_owner;
      m_gnt = '0; m_id = 0; m_valid = 1'b0;
    end else begin
      m_held++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic md, input logic rn);
    bus.req = r;
    bus.mode = md;
    rst_n = rn;
    @(posedge clk);
    model_update(r, md, rn);
    #1;
    chk("gnt",       32'(bus.gnt),       32'(m_gnt));
    chk("gnt_id",    32'(bus.gnt_id),    32'(m_id));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
    chk("timeout",   32'(bus.timeout),   32'(m_tmo));
    chk("onehot",    32'($onehot0(bus.gnt)), 32'd1);
    chk("valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
  endtask

  initial begin
    int exp_order [5];
    logic [3:0] r;
    logic md;
    exp_order = '{3, 2, 1, 0, 3};
    bus.req = '0;
    bus.mode = 1'b0;

    // Reset and first fixed-priority grant.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
    step(4'b0101, 1'b0, 1'b1);
    chk("fix_gnt", 32'(bus.gnt), 32'h4);
    chk("fix_id", 32'(bus.gnt_id), 32'd2);
    chk("fix_valid", 32'(bus.gnt_valid), 32'd1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // Round-robin rotation with all requesting, each owner holding 2 cycles.
    step(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk("rr_order", 32'(bus.gnt_id), 32'(exp_order[i]));
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << exp_order[i]));
      step(4'b1111, 1'b1, 1'b1);
      r = 4'b1111;
      r[exp_order[i]] = 1'b0;
      step(r, 1'b1, 1'b1);
      chk("rr_turnaround", 32'(bus.gnt_valid), 32'd0);
    end
    step(4'b0000, 1'b1, 1'b1);

    // Hold limit: lone requester forced off after MAX_HOLD cycles.
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0010, 1'b0, 1'b1);
      chk("hold_gnt", 32'(bus.gnt), 32'h2);
      chk("hold_tmo", 32'(bus.timeout), 32'd0);
    end
    step(4'b0010, 1'b0, 1'b1);
    chk("tmo_gnt", 32'(bus.gnt), 32'h0);
    chk("tmo_pulse", 32'(bus.timeout), 32'd1);
    step(4'b0010, 1'b0, 1'b1);
    chk("regrant_gnt", 32'(bus.gnt), 32'h2);
    chk("regrant_tmo", 32'(bus.timeout), 32'd0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // Mode sampled only at arbitration; last=3 before the round-robin pick.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b1010, 1'b1, 1'b1);
    chk("mode_rr_gnt", 32'(bus.gnt), 32'h2);
    step(4'b1010, 1'b0, 1'b1);
    chk("mode_hold_gnt", 32'(bus.gnt), 32'h2);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1011, 1'b0, 1'b1);
    chk("mode_fix_gnt", 32'(bus.gnt), 32'h8);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // Reset during a grant drops it silently.
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    chk("midrst_valid", 32'(bus.gnt_valid), 32'd0);
    chk("midrst_tmo", 32'(bus.timeout), 32'd0);
    step(4'b0011, 1'b0, 1'b1);
    chk("postrst_gnt", 32'(bus.gnt), 32'h2);
    step(4'b0000, 1'b0, 1'b1);

    // Random traffic: phase 0 random mode, phase 1 round-robin with fairness bound.
    for (int ph = 0; ph < 2; ph++) begin
      for (int p = 0; p < 4; p++) starve[p] = 0;
      prev_valid = bus.gnt_valid;
      chk_starve = (ph == 1);
      for (int cyc = 0; cyc < 1000; cyc++) begin
        for (int p = 0; p < 4; p++) begin
          if (!bus.req[p])     r[p] = ($urandom_range(0, 2) == 0);
          else if (bus.gnt[p]) r[p] = ($urandom_range(0, 3) != 0);
          else                 r[p] = ($urandom_range(0, 31) != 0);
        end
        md = (ph == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        step(r, md, 1'b1);
        if (!prev_valid && bus.gnt_valid) begin
          for (int p = 0; p < 4; p++) begin
            if (p == int'(bus.gnt_id)) starve[p] = 0;
            else if (r[p])             starve[p]++;
          end
          if (chk_starve) begin
            for (int p = 0; p < 4; p++) chk("starvation", 32'(starve[p] > 3), 32'd0);
          end
        end
        for (int p = 0; p < 4; p++) if (!r[p]) starve[p] = 0;
        prev_valid = bus.gnt_valid;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
